id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port stall  input  1  hold the EX-side contents this cycle.
REQ-005 The block SHALL have port flush  input  1  insert a bubble this cycle.
REQ-006 The block SHALL have port id_valid  input  1  decode slot holds a real instruction.
REQ-007 The block SHALL have port id_ALUctl  input  4  ALU operation code from decode.
REQ-008 The block SHALL have ports id_rs_data and id_rt_data  input  DATA_W each  register-file read data.
REQ-009 The block SHALL have ports id_imm  input  DATA_W  extended immediate; id_ALUSrc  input  1  B selects immediate.
REQ-010 The block SHALL have ports id_Shamt  input  5; id_rs, id_rt, id_rd  input  5 each; id_RegWrite  input  1.
REQ-011 The block SHALL have forwarding ports mem_RegWrite  input  1, mem_rd  input  5, mem_result  input  DATA_W, wb_RegWrite  input  1, wb_rd  input  5, wb_result  input  DATA_W.
REQ-012 The block SHALL have outputs ex_valid  1; ALUctl  4; A  DATA_W; B  DATA_W; Shamt  5; ex_rd  5; ex_RegWrite  1; ex_store_data  DATA_W.

Function
REQ-013 On each rising clk with stall=0 and flush=0, the block SHALL capture all id_* inputs into the EX register set; latency decode-to-EX is one cycle.
REQ-014 With flush=1 at a rising edge, the block SHALL clear ex_valid, ex_RegWrite and ALUctl to 0 and leave the other fields unchanged; flush SHALL take priority over stall.
REQ-015 With stall=1 and flush=0, the block SHALL hold every captured field except the rs and rt data registers, which SHALL be reloaded with their forwarded values (REQ-017), so a producer retiring from MEM/WB during the stall is not lost.
REQ-016 Operand forwarding SHALL be combinational from the captured registers and the current mem_*/wb_* inputs.
REQ-017 Forwarded rs value: mem_result if mem_RegWrite=1, mem_rd=rs and rs!=0; else wb_result if wb_RegWrite=1, wb_rd=rs and rs!=0; else the captured rs data. The same rule SHALL apply to rt. MEM SHALL beat WB.
REQ-018 A SHALL equal the forwarded rs value.
REQ-019 B SHALL equal the captured immediate when the captured ALUSrc=1, else the forwarded rt value.
REQ-020 ex_store_data SHALL equal the forwarded rt value regardless of ALUSrc.
REQ-021 Shamt, ALUctl, ex_rd and ex_RegWrite SHALL drive the captured values directly.
REQ-022 Register 0 SHALL never be forwarded, even when a producer targets it.
REQ-023 A bubble (ex_valid=0) SHALL present ex_RegWrite=0 so that downstream stages never write back.
REQ-024 id_valid=0 captured normally SHALL yield ex_valid=0 and ex_RegWrite=0 regardless of id_RegWrite.

Reset
REQ-025 While reset=1, asynchronously and independent of clk, all EX registers SHALL clear to 0, so ex_valid=0, ALUctl=0, A=0, B=0, Shamt=0, ex_rd=0, ex_RegWrite=0 and ex_store_data=0, absent forwarding hits.
REQ-026 Reset asserted mid-stall or mid-flush SHALL override both. The first capture SHALL occur on the first rising clk after deassertion.

Verification
REQ-027 Capture: id_ALUctl=0010, rs_data=5, rt_data=7, ALUSrc=0, no forwarding hits; one edge -> ALUctl=0010, A=5, B=7, ex_valid=1.
REQ-028 Forward priority: captured rs=3, mem_rd=3 with mem_result=0x11, wb_rd=3 with wb_result=0x22, both RegWrite=1 -> A=0x11. Deassert mem_RegWrite -> A=0x22.
REQ-029 Reg0: rs=0, rs_data=0, mem_rd=0, mem_RegWrite=1, mem_result=0xFFFF -> A=0.
REQ-030 Stall retention: captured rt=4, ALUSrc=0, stall=1, wb_rd=4 with wb_result=9 for one edge, then wb_RegWrite=0 -> B stays 9. All other fields stay unchanged.
REQ-031 Flush vs stall: stall=1 and flush=1 on the same edge -> ex_valid=0, ex_RegWrite=0, ALUctl=0.
REQ-032 Async reset: assert reset between edges with ex_valid=1 -> ex_valid=0 and ALUctl=0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Pipeline register between decode (ID) and execute (EX), plus the operand
// forwarding muxes that sit at the front of EX. The register set is loaded
// from the decode slot each cycle. It can hold (stall) or be turned into a
// bubble (flush). The A/B/store-data operands are resolved combinationally
// against results still in flight in MEM and WB.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   stall            hold the EX contents (rs/rt data still track forwarding)
//   flush            turn the EX slot into a bubble; wins over stall
//   id_*             decode-side instruction fields to capture
//   mem_RegWrite, mem_rd, mem_result   producer currently in MEM
//   wb_RegWrite,  wb_rd,  wb_result    producer currently in WB
//   ex_valid, ALUctl, Shamt, ex_rd, ex_RegWrite   captured control fields
//   A, B, ex_store_data                           forwarded operands
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_ALUctl,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_ALUSrc,
  input  logic [4:0]        id_Shamt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_RegWrite,
  input  logic              mem_RegWrite,
  input  logic [4:0]        mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              ex_valid,
  output logic [3:0]        ALUctl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [4:0]        Shamt,
  output logic [4:0]        ex_rd,
  output logic              ex_RegWrite,
  output logic [DATA_W-1:0] ex_store_data
);

  logic              valid_q;
  logic [3:0]        alu_ctl_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  logic [4:0]        shamt_q;
  logic [4:0]        rs_q;
  logic [4:0]        rt_q;
  logic [4:0]        rd_q;
  logic              reg_write_q;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // Forwarding: MEM is the younger producer, so it is checked first.
  // Register 0 is hard-wired to zero and is never forwarded.
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_RegWrite && (mem_rd == rs_q) && (rs_q != 5'd0)) begin
      fwd_rs = mem_result;
    end else if (wb_RegWrite && (wb_rd == rs_q) && (rs_q != 5'd0)) begin
      fwd_rs = wb_result;
    end

    fwd_rt = rt_data_q;
    if (mem_RegWrite && (mem_rd == rt_q) && (rt_q != 5'd0)) begin
      fwd_rt = mem_result;
    end else if (wb_RegWrite && (wb_rd == rt_q) && (rt_q != 5'd0)) begin
      fwd_rt = wb_result;
    end
  end

  // EX register set. During a stall the rs/rt data registers soak up the
  // forwarded values so a producer that retires from WB while we wait is
  // not lost once it drops off the forwarding path. A flush only kills
  // the fields that could cause side effects; the rest are left as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_ctl_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      shamt_q     <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      alu_ctl_q   <= '0;
      reg_write_q <= 1'b0;
    end else if (stall) begin
      rs_data_q   <= fwd_rs;
      rt_data_q   <= fwd_rt;
    end else begin
      valid_q     <= id_valid;
      alu_ctl_q   <= id_ALUctl;
      rs_data_q   <= id_rs_data;
      rt_data_q   <= id_rt_data;
      imm_q       <= id_imm;
      alu_src_q   <= id_ALUSrc;
      shamt_q     <= id_Shamt;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rd_q        <= id_rd;
      // An invalid decode slot must never be allowed to write back.
      reg_write_q <= id_valid & id_RegWrite;
    end
  end

  assign ex_valid      = valid_q;
  assign ALUctl        = alu_ctl_q;
  assign Shamt         = shamt_q;
  assign ex_rd         = rd_q;
  assign ex_RegWrite   = reg_write_q;
  assign A             = fwd_rs;
  assign B             = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage. Each step drives the decode and forwarding
// inputs. It pushes the outputs it expects onto a scoreboard queue. After
// the clock edge, or after the combinational settle, it pops that entry and
// compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [3:0]        id_ALUctl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_ALUSrc;
  logic [4:0]        id_Shamt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              id_RegWrite;
  logic              mem_RegWrite;
  logic [4:0]        mem_rd;
  logic [DATA_W-1:0] mem_result;
  logic              wb_RegWrite;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_result;
  logic              ex_valid;
  logic [3:0]        ALUctl;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [4:0]        Shamt;
  logic [4:0]        ex_rd;
  logic              ex_RegWrite;
  logic [DATA_W-1:0] ex_store_data;

  typedef struct {
    string             tag;
    logic              valid;
    logic [3:0]        ctl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        shamt;
    logic [4:0]        rd;
    logic              rw;
    logic [DATA_W-1:0] store;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ALUctl    (id_ALUctl),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_imm       (id_imm),
    .id_ALUSrc    (id_ALUSrc),
    .id_Shamt     (id_Shamt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_RegWrite  (id_RegWrite),
    .mem_RegWrite (mem_RegWrite),
    .mem_rd       (mem_rd),
    .mem_result   (mem_result),
    .wb_RegWrite  (wb_RegWrite),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .ex_valid     (ex_valid),
    .ALUctl       (ALUctl),
    .A            (A),
    .B            (B),
    .Shamt        (Shamt),
    .ex_rd        (ex_rd),
    .ex_RegWrite  (ex_RegWrite),
    .ex_store_data(ex_store_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never reaches its summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one decode slot.
  task automatic applyStimulus(input logic v, input logic [3:0] ctl,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd,
                               input logic [DATA_W-1:0] rsd,
                               input logic [DATA_W-1:0] rtd,
                               input logic [DATA_W-1:0] imm,
                               input logic src, input logic [4:0] sh,
                               input logic rw);
    id_valid    = v;
    id_ALUctl   = ctl;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_rs_data  = rsd;
    id_rt_data  = rtd;
    id_imm      = imm;
    id_ALUSrc   = src;
    id_Shamt    = sh;
    id_RegWrite = rw;
  endtask

  // Push the outputs expected for the step just driven.
  task automatic expectOut(input string tag, input logic v,
                           input logic [3:0] ctl,
                           input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b,
                           input logic [4:0] sh, input logic [4:0] rd,
                           input logic rw,
                           input logic [DATA_W-1:0] st);
    exp_t e;
    e.tag   = tag;
    e.valid = v;
    e.ctl   = ctl;
    e.a     = a;
    e.b     = b;
    e.shamt = sh;
    e.rd    = rd;
    e.rw    = rw;
    e.store = st;
    sb_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, want %h", tag, field, obs, exp);
      $error("[TB] %s.%s got %h want %h", tag, field, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want an entry");
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, "ex_valid",      {31'd0, ex_valid},    {31'd0, e.valid});
      cmp(e.tag, "ALUctl",        {28'd0, ALUctl},      {28'd0, e.ctl});
      cmp(e.tag, "A",             A,                    e.a);
      cmp(e.tag, "B",             B,                    e.b);
      cmp(e.tag, "Shamt",         {27'd0, Shamt},       {27'd0, e.shamt});
      cmp(e.tag, "ex_rd",         {27'd0, ex_rd},       {27'd0, e.rd});
      cmp(e.tag, "ex_RegWrite",   {31'd0, ex_RegWrite}, {31'd0, e.rw});
      cmp(e.tag, "ex_store_data", ex_store_data,        e.store);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    mem_RegWrite = 1'b0;
    mem_rd       = '0;
    mem_result   = '0;
    wb_RegWrite  = 1'b0;
    wb_rd        = '0;
    wb_result    = '0;
    applyStimulus(0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0);

    // Reset state
    expectOut("reset", 0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 32'h0);
    #2;
    checkOutput();

    // Edges while reset is held do not capture
    applyStimulus(1, 4'h2, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'h100, 0, 5'd3, 1);
    expectOut("reset_hold", 0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 32'h0);
    tick();
    checkOutput();

    // Basic capture, first edge after reset release
    expectOut("capture", 1, 4'h2, 32'd5, 32'd7, 5'd3, 5'd5, 1, 32'd7);
    reset = 1'b0;
    tick();
    checkOutput();

    // B selects the immediate; store data still carries rt
    applyStimulus(1, 4'h6, 5'd6, 5'd7, 5'd8, 32'h10, 32'h20, 32'h300, 1, 5'd0, 1);
    expectOut("alusrc_imm", 1, 4'h6, 32'h10, 32'h300, 5'd0, 5'd8, 1, 32'h20);
    tick();
    checkOutput();

    // Forwarding priority on rs: MEM beats WB
    applyStimulus(1, 4'h1, 5'd3, 5'd9, 5'd3, 32'hAA, 32'hBB, 32'h0, 0, 5'd0, 1);
    mem_RegWrite = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
    wb_RegWrite  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'h22;
    expectOut("fwd_mem", 1, 4'h1, 32'h11, 32'hBB, 5'd0, 5'd3, 1, 32'hBB);
    tick();
    checkOutput();
    mem_RegWrite = 1'b0;
    expectOut("fwd_wb", 1, 4'h1, 32'h22, 32'hBB, 5'd0, 5'd3, 1, 32'hBB);
    #1;
    checkOutput();
    wb_RegWrite = 1'b0;
    expectOut("fwd_none", 1, 4'h1, 32'hAA, 32'hBB, 5'd0, 5'd3, 1, 32'hBB);
    #1;
    checkOutput();

    // Forwarding on rt feeds both B and store data
    wb_RegWrite = 1'b1; wb_rd = 5'd9; wb_result = 32'h33;
    expectOut("fwd_rt_wb", 1, 4'h1, 32'hAA, 32'h33, 5'd0, 5'd3, 1, 32'h33);
    #1;
    checkOutput();
    mem_RegWrite = 1'b1; mem_rd = 5'd9; mem_result = 32'h44;
    expectOut("fwd_rt_mem", 1, 4'h1, 32'hAA, 32'h44, 5'd0, 5'd3, 1, 32'h44);
    #1;
    checkOutput();
    mem_RegWrite = 1'b0;
    wb_RegWrite  = 1'b0;

    // Register 0 is never forwarded
    applyStimulus(1, 4'h2, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 0);
    mem_RegWrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFFFF;
    wb_RegWrite  = 1'b1; wb_rd  = 5'd0; wb_result  = 32'h1234;
    expectOut("reg0", 1, 4'h2, 32'h0, 32'h0, 5'd0, 5'd0, 0, 32'h0);
    tick();
    checkOutput();
    mem_RegWrite = 1'b0;
    wb_RegWrite  = 1'b0;

    // Invalid decode slot never writes back
    applyStimulus(0, 4'h3, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'h0, 0, 5'd0, 1);
    expectOut("id_invalid", 0, 4'h3, 32'd1, 32'd2, 5'd0, 5'd7, 0, 32'd2);
    tick();
    checkOutput();

    // Stall retention of a WB producer on rt
    applyStimulus(1, 4'h5, 5'd10, 5'd4, 5'd12, 32'h40, 32'h50, 32'h999, 0, 5'd7, 1);
    expectOut("stall_load", 1, 4'h5, 32'h40, 32'h50, 5'd7, 5'd12, 1, 32'h50);
    tick();
    checkOutput();
    stall = 1'b1;
    applyStimulus(0, 4'hF, 5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 32'h0, 1, 5'd1, 0);
    wb_RegWrite = 1'b1; wb_rd = 5'd4; wb_result = 32'd9;
    expectOut("stall_fwd", 1, 4'h5, 32'h40, 32'd9, 5'd7, 5'd12, 1, 32'd9);
    #1;
    checkOutput();
    tick();
    wb_RegWrite = 1'b0;
    expectOut("stall_hold", 1, 4'h5, 32'h40, 32'd9, 5'd7, 5'd12, 1, 32'd9);
    #1;
    checkOutput();
    expectOut("stall_hold2", 1, 4'h5, 32'h40, 32'd9, 5'd7, 5'd12, 1, 32'd9);
    tick();
    checkOutput();

    // Flush wins over stall; only valid/RegWrite/ALUctl are cleared
    flush = 1'b1;
    expectOut("flush_stall", 0, 4'h0, 32'h40, 32'd9, 5'd7, 5'd12, 0, 32'd9);
    tick();
    checkOutput();
    flush = 1'b0;
    stall = 1'b0;

    // Asynchronous reset between edges, overriding stall and flush
    applyStimulus(1, 4'h2, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h0, 0, 5'd2, 1);
    expectOut("pre_reset", 1, 4'h2, 32'h55, 32'h66, 5'd2, 5'd3, 1, 32'h66);
    tick();
    checkOutput();
    #2;
    reset = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    expectOut("async_reset", 0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 32'h0);
    #1;
    checkOutput();
    expectOut("reset_over_stall", 0, 4'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 32'h0);
    tick();
    checkOutput();

    // First capture after reset release
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1, 4'h7, 5'd2, 5'd3, 5'd9, 32'h77, 32'h88, 32'h0, 0, 5'd1, 1);
    reset = 1'b0;
    expectOut("first_capture", 1, 4'h7, 32'h77, 32'h88, 5'd1, 5'd9, 1, 32'h88);
    tick();
    checkOutput();

    cmp("scoreboard", "leftover", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
